multiplexer_16_to_1_registered: RTL and testbench



---
 rtl/multiplexer_16_to_1_registered.sv | 62 ++++++
 tb/tb_multiplexer_16_to_1_registered.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/multiplexer_16_to_1_registered.sv
// Registered 16:1 read-port multiplexer for the register file operand buses.
// A 4-bit control code picks one of sixteen words; the choice is registered with async clear.
module multiplexer_16_to_1_registered #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    input  logic [WIDTH-1:0] data4,
    input  logic [WIDTH-1:0] data5,
    input  logic [WIDTH-1:0] data6,
    input  logic [WIDTH-1:0] data7,
    input  logic [WIDTH-1:0] data8,
    input  logic [WIDTH-1:0] data9,
    input  logic [WIDTH-1:0] data10,
    input  logic [WIDTH-1:0] data11,
    input  logic [WIDTH-1:0] data12,
    input  logic [WIDTH-1:0] data13,
    input  logic [WIDTH-1:0] data14,
    input  logic [WIDTH-1:0] data15,
    input  logic [WIDTH-1:0] data16,
    input  logic [3:0]       control,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] sel_c;

    // Full 16-way decode: every control code maps to exactly one input word.
    always_comb begin
        sel_c = data1;
        unique case (control)
            4'd0:  sel_c = data1;
            4'd1:  sel_c = data2;
            4'd2:  sel_c = data3;
            4'd3:  sel_c = data4;
            4'd4:  sel_c = data5;
            4'd5:  sel_c = data6;
            4'd6:  sel_c = data7;
            4'd7:  sel_c = data8;
            4'd8:  sel_c = data9;
            4'd9:  sel_c = data10;
            4'd10: sel_c = data11;
            4'd11: sel_c = data12;
            4'd12: sel_c = data13;
            4'd13: sel_c = data14;
            4'd14: sel_c = data15;
            4'd15: sel_c = data16;
        endcase
    end

    // Output register loads every cycle; clr low clears it immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out <= '0;
        end else begin
            out <= sel_c;
        end
    end

endmodule

// File: tb/tb_multiplexer_16_to_1_registered.sv
// Scoreboard bench for multiplexer_16_to_1_registered: expected words are queued at drive
// time and popped one cycle later; stability between edges and async clear are also checked.
module tb_multiplexer_16_to_1_registered;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             clr;
    logic [WIDTH-1:0] d [16];
    logic [3:0]       control;
    logic [WIDTH-1:0] dout;

    logic [WIDTH-1:0] sb [$];
    int unsigned      n_cmp;
    int unsigned      n_err;

    multiplexer_16_to_1_registered #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .clr     (clr),
        .data1   (d[0]),
        .data2   (d[1]),
        .data3   (d[2]),
        .data4   (d[3]),
        .data5   (d[4]),
        .data6   (d[5]),
        .data7   (d[6]),
        .data8   (d[7]),
        .data9   (d[8]),
        .data10  (d[9]),
        .data11  (d[10]),
        .data12  (d[11]),
        .data13  (d[12]),
        .data14  (d[13]),
        .data15  (d[14]),
        .data16  (d[15]),
        .control (control),
        .out     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Let one rising edge capture, compare against the queued word, then confirm it holds to the falling edge.
    task automatic step(input string tag);
        logic [WIDTH-1:0] e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h", tag, dout);
        end else begin
            e = sb.pop_front();
            check(tag, dout, e);
            @(negedge clk);
            check({tag, "_hold"}, dout, e);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        control = 4'd0;
        for (int i = 0; i < 16; i++) d[i] = WIDTH'(i + 1);
        clr = 1'b1;
        #2;
        clr = 1'b0;

        // Reset held: out stays zero across edges even with data1 non-zero.
        d[0] = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", dout, '0);
        end
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("reset_release", dout, '0);

        // Select 0, with an unselected input undriven-looking.
        control = 4'd0;
        d[0]    = 32'h0000_0001;
        d[1]    = 32'h0000_000A;
        d[5]    = 'x;
        sb.push_back(32'h0000_0001);
        step("sel0");
        d[5]    = 32'h0000_0006;

        // Select 1, then a data change that must not show until the next edge.
        control = 4'd1;
        sb.push_back(32'h0000_000A);
        step("sel1");
        d[1] = 32'h0000_000B;
        #1;
        check("sel1_no_early", dout, 32'h0000_000A);
        sb.push_back(32'h0000_000B);
        step("sel1_change");

        // Select 14 among distinct inputs.
        for (int i = 0; i < 16; i++) d[i] = WIDTH'(i + 1);
        d[14]   = 32'h0000_0BBB;
        control = 4'd14;
        sb.push_back(32'h0000_0BBB);
        step("sel14");

        // Exhaustive sweep of all codes.
        for (int i = 0; i < 16; i++) d[i] = 32'hA5A5_0000 + WIDTH'(i + 1);
        for (int c = 0; c < 16; c++) begin
            control = 4'(c);
            sb.push_back(32'hA5A5_0001 + WIDTH'(c));
            step($sformatf("sweep%0d", c));
        end

        // Async clear mid-cycle with a non-zero output, recovery with control=7.
        control = 4'd3;
        sb.push_back(32'hA5A5_0004);
        step("pre_clr");
        #1;
        clr = 1'b0;
        #1;
        check("clr_async", dout, '0);
        control = 4'd7;
        #1;
        clr = 1'b1;
        #1;
        check("clr_released_wait", dout, '0);
        sb.push_back(32'hA5A5_0008);
        step("clr_recover");

        // Random operation after recovery.
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 16; i++) d[i] = $urandom;
            control = 4'($urandom_range(0, 15));
            sb.push_back(d[control]);
            step($sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 100000", $time);
        $fatal(1);
    end

endmodule
